// File: rtl/veto_err_monitor_if.sv
// Signal bundle between the spill-control side and the veto error monitor.
// The master side drives the live gate, strobe, bus and mask; the monitor reports results.
interface veto_err_monitor_if #(
    parameter int N_GRP = 29,
    parameter int GRP_W = 8,
    parameter int IDX_W = 8,
    parameter int CNT_W = 16
);
    logic                   in_live;
    logic                   got_veto_err;
    logic [N_GRP*GRP_W-1:0] veto_err_bus;
    logic [N_GRP*GRP_W-1:0] err_mask;
    logic                   clr_cnt;
    logic                   busy;
    logic                   scan_done;
    logic                   is_veto_err;
    logic [N_GRP-1:0]       err_grp;
    logic [IDX_W-1:0]       first_err_ch;
    logic [IDX_W-1:0]       n_err_grp;
    logic [CNT_W-1:0]       err_spill_cnt;

    modport master (
        output in_live, got_veto_err, veto_err_bus, err_mask, clr_cnt,
        input  busy, scan_done, is_veto_err, err_grp, first_err_ch, n_err_grp, err_spill_cnt
    );

    modport slave (
        input  in_live, got_veto_err, veto_err_bus, err_mask, clr_cnt,
        output busy, scan_done, is_veto_err, err_grp, first_err_ch, n_err_grp, err_spill_cnt
    );
endinterface

// File: rtl/veto_err_monitor.sv
// Per-spill veto error monitor: snapshots the masked error bus on the first strobe of a
// live period, then scans one channel group per cycle to build the summary results.
module veto_err_monitor #(
    parameter int N_GRP = 29,
    parameter int GRP_W = 8,
    parameter int IDX_W = 8,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    veto_err_monitor_if.slave vif
);
    localparam int BUS_W = N_GRP * GRP_W;

    typedef enum logic [1:0] {IDLE, ARMED, SCAN, DONE} state_t;

    state_t             state_q, state_d;
    logic [BUS_W-1:0]   snap_q;
    logic [IDX_W-1:0]   grp_idx_q;
    logic               busy_q, scan_done_q, is_err_q;
    logic [N_GRP-1:0]   err_grp_q;
    logic [IDX_W-1:0]   first_q, n_err_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               capture, scan_step, last_grp, grp_nz;
    logic [IDX_W-1:0]   grp_base;
    logic [GRP_W-1:0]   grp_bits;
    logic [IDX_W-1:0]   grp_lsb;

    function automatic logic [IDX_W-1:0] lowest_bit(input logic [GRP_W-1:0] v);
        logic [IDX_W-1:0] pos;
        pos = '0;
        for (int i = GRP_W - 1; i >= 0; i--)
            if (v[i]) pos = IDX_W'(i);
        return pos;
    endfunction

    assign grp_base = grp_idx_q * IDX_W'(GRP_W);
    assign grp_bits = GRP_W'(snap_q >> grp_base);
    assign grp_nz   = |grp_bits;
    assign grp_lsb  = lowest_bit(grp_bits);
    assign last_grp = (grp_idx_q == IDX_W'(N_GRP - 1));

    // Dropping in_live overrides every state, so abort and re-arm share one path.
    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        scan_step = 1'b0;
        if (!vif.in_live) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:  state_d = ARMED;
                ARMED: if (vif.got_veto_err) begin
                    capture = 1'b1;
                    state_d = SCAN;
                end
                SCAN: begin
                    scan_step = 1'b1;
                    if (last_grp) state_d = DONE;
                end
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            snap_q      <= '0;
            grp_idx_q   <= '0;
            busy_q      <= 1'b0;
            scan_done_q <= 1'b0;
            is_err_q    <= 1'b0;
            err_grp_q   <= '0;
            first_q     <= '1;
            n_err_q     <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            scan_done_q <= 1'b0;
            if (!vif.in_live) begin
                busy_q    <= 1'b0;
                grp_idx_q <= '0;
                is_err_q  <= 1'b0;
                err_grp_q <= '0;
                first_q   <= '1;
                n_err_q   <= '0;
            end else if (capture) begin
                snap_q    <= vif.veto_err_bus & ~vif.err_mask;
                grp_idx_q <= '0;
                busy_q    <= 1'b1;
            end else if (scan_step) begin
                err_grp_q <= err_grp_q | (N_GRP'(grp_nz) << grp_idx_q);
                if (grp_nz) n_err_q <= n_err_q + IDX_W'(1);
                if (grp_nz && (first_q == '1)) first_q <= grp_base + grp_lsb;
                grp_idx_q <= grp_idx_q + IDX_W'(1);
                if (last_grp) begin
                    busy_q      <= 1'b0;
                    scan_done_q <= 1'b1;
                    is_err_q    <= |snap_q;
                end
            end

            // Clear beats a coincident end-of-scan increment.
            if (vif.clr_cnt)
                cnt_q <= '0;
            else if (scan_step && last_grp && (|snap_q) && (cnt_q != '1))
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign vif.busy          = busy_q;
    assign vif.scan_done     = scan_done_q;
    assign vif.is_veto_err   = is_err_q;
    assign vif.err_grp       = err_grp_q;
    assign vif.first_err_ch  = first_q;
    assign vif.n_err_grp     = n_err_q;
    assign vif.err_spill_cnt = cnt_q;
endmodule

// File: doc/veto_err_monitor.md
# veto_err_monitor

Per-spill veto error monitor for the Top CDT trigger path. It is the parametrised successor to the single-bit veto error flag. Once per live period it captures the veto error bus on the first error strobe, applies a per-channel mask, and scans the snapshot one group per cycle. It reports:
- a summary flag;
- a per-group error map;
- the lowest errored channel index;
- the errored-group count;
- a saturating count of spills with veto errors.

## Interface
- N_GRP, 29, number of channel groups scanned (one per cycle)
- GRP_W, 8, channels per group; bus width is N_GRP*GRP_W
- IDX_W, 8, index/count width; must satisfy 2^IDX_W > N_GRP*GRP_W
- CNT_W, 16, width of the spill error counter
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- in_live  in  1  live gate; low = between spills
- got_veto_err  in  1  veto error bus strobe; first sample per live period is used
- veto_err_bus  in  N_GRP*GRP_W  per-channel error bits
- err_mask  in  N_GRP*GRP_W  1 = channel ignored; sampled with the bus
- clr_cnt  in  1  clears err_spill_cnt
- busy  out  1  scan in progress
- scan_done  out  1  one-cycle pulse when results become valid
- is_veto_err  out  1  any unmasked error in the snapshot
- err_grp  out  N_GRP  bit k = group k has an unmasked error
- first_err_ch  out  IDX_W  lowest errored channel; all-ones if none
- n_err_grp  out  IDX_W  number of errored groups
- err_spill_cnt  out  CNT_W  spills with is_veto_err=1, saturating

## Operation
- **States:** IDLE, ARMED, SCAN, DONE.
- **IDLE:**
  - Result outputs are held at their cleared values: is_veto_err=0, err_grp=0, n_err_grp=0, first_err_ch=all-ones.
  - Moves to ARMED when in_live=1.
  - got_veto_err is ignored.
- **ARMED:**
  - When got_veto_err=1, the block latches snap = veto_err_bus & ~err_mask, sets grp_idx=0 and busy=1, and goes to SCAN.
- **SCAN:** each cycle processes group k=grp_idx:
  - err_grp[k] <= |snap[k*GRP_W +: GRP_W].
  - If the group is nonzero, n_err_grp increments.
  - If the group is nonzero and first_err_ch is still all-ones, first_err_ch <= k*GRP_W + position of the lowest set bit in the group.
  - On k = N_GRP-1, the state goes to DONE, busy=0, scan_done=1 for one cycle, and is_veto_err <= (snap != 0).
  - If is_veto_err is 1, err_spill_cnt increments, saturating at all-ones.
- **DONE:** results are held; further got_veto_err strobes are ignored.
- **in_live=0 in any state:** the next state is IDLE and all results clear.
  - If this happens during SCAN, the scan is aborted: no scan_done pulse and no counter increment.
- **clr_cnt:** err_spill_cnt <= 0. If it coincides with an increment, the clear wins.
- **Arithmetic:** all index and count arithmetic is unsigned, IDX_W bits wide. n_err_grp cannot exceed N_GRP.

## Timing
- **Reset (rst=1 at an edge):**
  - State goes to IDLE.
  - busy=0, scan_done=0, is_veto_err=0, err_grp=0, n_err_grp=0, err_spill_cnt=0, first_err_ch=all-ones.
  - Reset overrides every other input, including during SCAN.
- **Strobe capture:** a strobe sampled at edge E0 in ARMED sets busy high after E0.
- **Scan sequence:**
  - Groups 0..N_GRP-1 are processed at edges E1..E_N.
  - scan_done is high for exactly the cycle after E_N (N_GRP+1 edges after the strobe sample).
  - All results are valid from that cycle until in_live falls.
- **Intermediate values:** err_grp, n_err_grp and first_err_ch update progressively during SCAN. They are defined as final only when scan_done is high or the state is DONE.
- **Strobe on the live-rise cycle:** got_veto_err sampled on the same edge that moves IDLE to ARMED is ignored. The earliest usable strobe is one cycle after in_live rises.
- **Minimum live gap:** one low cycle of in_live is sufficient to clear results and re-arm.

## Test plan
- **Reset mid-scan:** rst high for one cycle during SCAN -> all outputs at reset values the next cycle, and err_spill_cnt=0.
- **Single error (defaults):** bit 37 set, mask 0, strobe -> scan_done 30 cycles after the strobe edge, is_veto_err=1, err_grp=29'h10, first_err_ch=37, n_err_grp=1, err_spill_cnt=1.
- **Masked and multi-group errors:** bits 3, 200 and 231 set, bit 3 masked -> err_grp bits 25 and 28 set, first_err_ch=200, n_err_grp=2. A second strobe in DONE changes nothing.
- **Clean spill and sentinel:** bus=0, strobe -> is_veto_err=0, first_err_ch=8'hFF, n_err_grp=0, counter unchanged. in_live dropped during SCAN -> no scan_done pulse and results cleared.
- **Counter saturation and clear:** CNT_W=2 with four error spills -> err_spill_cnt stays at 3. clr_cnt coincident with an increment -> 0.
